// File: rtl/axi4l_uart_regs.sv
// AXI4-Lite register front-end for the UART core: TX push, RX pop, status and control.
// Define UART_REGS_SCRATCH_EN to build the 32-bit SCRATCH register at offset 0x10.
module axi4l_uart_regs #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  input  logic [3:0]                wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [7:0]                tx_data,
  output logic                      tx_wr_en,
  input  logic                      tx_full,
  input  logic [7:0]                rx_data,
  output logic                      rx_rd_en,
  input  logic                      rx_empty,
  input  logic                      rx_overrun,
  output logic [2:0]                ctrl
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] REG_TX      = 3'd0;
  localparam logic [2:0] REG_RX      = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
`ifdef UART_REGS_SCRATCH_EN
  localparam logic [2:0] REG_SCRATCH = 3'd4;
`endif

  typedef enum logic [1:0] {W_IDLE, W_CAPT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e w_state, w_state_next;
  r_state_e r_state, r_state_next;

  logic                      aw_hs, w_hs, ar_hs, wr_fire;
  logic                      aw_have, w_have;
  logic [2:0]                aw_sel_q, wr_sel;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wr_data;
  logic [3:0]                wstrb_q, wr_strb;
  logic                      overrun;

  logic [1:0]                wr_resp;
  logic                      tx_push, ctrl_we, ovr_clr;
  logic [1:0]                rd_resp;
  logic [AXI_DATA_WIDTH-1:0] rd_val;
  logic                      rx_pop;

`ifdef UART_REGS_SCRATCH_EN
  logic [AXI_DATA_WIDTH-1:0] scratch;
  logic                      scratch_we;
`endif

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;
  // The write commits in the cycle its second half arrives, whichever channel that is.
  assign wr_fire = (aw_hs | aw_have) & (w_hs | w_have);

  assign wr_sel  = aw_hs ? awaddr[4:2] : aw_sel_q;
  assign wr_data = w_hs ? wdata : wdata_q;
  assign wr_strb = w_hs ? wstrb : wstrb_q;

  assign bvalid  = (w_state == W_RESP);
  assign rvalid  = (r_state == R_DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      // NOTE: every flop uses <= so all state updates see pre-edge values, whatever the block order.
      w_state <= w_state_next;
      r_state <= r_state_next;
    end
  end

  always_comb begin
    // NOTE: default first, so no path through the case leaves the signal unassigned (no latch).
    w_state_next = w_state;
    case (w_state)
      W_IDLE, W_CAPT: begin
        if (wr_fire)            w_state_next = W_RESP;
        else if (aw_hs || w_hs) w_state_next = W_CAPT;
      end
      W_RESP:  if (bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)  r_state_next = R_DATA;
      R_DATA:  if (rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Write side effects are only decoded for the committing cycle.
  always_comb begin
    wr_resp = RESP_OKAY;
    tx_push = 1'b0;
    ctrl_we = 1'b0;
    ovr_clr = 1'b0;
`ifdef UART_REGS_SCRATCH_EN
    scratch_we = 1'b0;
`endif
    if (wr_fire) begin
      case (wr_sel)
        REG_TX: begin
          if (wr_strb[0]) begin
            if (tx_full) wr_resp = RESP_SLVERR;
            else         tx_push = 1'b1;
          end
        end
        REG_STATUS:  ovr_clr = wr_data[2];
        REG_CTRL:    ctrl_we = wr_strb[0];
`ifdef UART_REGS_SCRATCH_EN
        REG_SCRATCH: scratch_we = 1'b1;
`endif
        default:     wr_resp = RESP_SLVERR;
      endcase
    end
  end

  always_comb begin
    rd_resp = RESP_OKAY;
    rd_val  = '0;
    rx_pop  = 1'b0;
    case (araddr[4:2])
      REG_RX: begin
        if (rx_empty) begin
          rd_resp = RESP_SLVERR;
        end else begin
          rd_val[7:0] = rx_data;
          rx_pop      = ar_hs;
        end
      end
      REG_STATUS:  rd_val[2:0] = {overrun, rx_empty, tx_full};
      REG_CTRL:    rd_val[2:0] = ctrl;
`ifdef UART_REGS_SCRATCH_EN
      REG_SCRATCH: rd_val = scratch;
`endif
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      arready  <= 1'b0;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      aw_sel_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp    <= RESP_OKAY;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
      tx_wr_en <= 1'b0;
      tx_data  <= '0;
      rx_rd_en <= 1'b0;
      ctrl     <= '0;
      overrun  <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      rx_rd_en <= 1'b0;

      if (aw_hs)                                     awready <= 1'b0;
      else if (w_state == W_IDLE || (bvalid && bready)) awready <= 1'b1;
      if (w_hs)                                      wready  <= 1'b0;
      else if (w_state == W_IDLE || (bvalid && bready)) wready  <= 1'b1;
      if (ar_hs)                                     arready <= 1'b0;
      else if (r_state == R_IDLE || (rvalid && rready)) arready <= 1'b1;

      if (aw_hs) aw_sel_q <= awaddr[4:2];
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end

      if (wr_fire) begin
        aw_have  <= 1'b0;
        w_have   <= 1'b0;
        bresp    <= wr_resp;
        tx_wr_en <= tx_push;
        if (tx_push) tx_data <= wr_data[7:0];
        if (ctrl_we) ctrl    <= wr_data[2:0];
      end else begin
        if (aw_hs) aw_have <= 1'b1;
        if (w_hs)  w_have  <= 1'b1;
      end

      // A new overrun outranks a simultaneous W1C clear.
      if (rx_overrun)   overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;

      if (ar_hs) begin
        rdata    <= rd_val;
        rresp    <= rd_resp;
        rx_rd_en <= rx_pop;
      end
    end
  end

`ifdef UART_REGS_SCRATCH_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scratch <= '0;
    end else if (scratch_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) scratch[8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end
`endif

  // Address bits outside [4:2] and unused data/strobe lanes are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{awaddr, araddr, wdata, wstrb, wdata_q, wstrb_q};

endmodule

// File: tb/tb_axi4l_uart_regs.sv
// Directed self-checking bench for axi4l_uart_regs; expectations follow UART_REGS_SCRATCH_EN.
module tb_axi4l_uart_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  tx_data, rx_data;
  logic        tx_wr_en, tx_full, rx_rd_en, rx_empty, rx_overrun;
  logic [2:0]  ctrl;

  int          checks = 0;
  int          errors = 0;
  int          tx_pushes = 0;
  int          rx_pops = 0;
  logic [7:0]  last_tx = 8'h00;

  always #5 clk = ~clk;

  axi4l_uart_regs dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
    .rx_data(rx_data), .rx_rd_en(rx_rd_en), .rx_empty(rx_empty),
    .rx_overrun(rx_overrun), .ctrl(ctrl)
  );

  always @(posedge clk) begin
    if (tx_wr_en) begin
      tx_pushes <= tx_pushes + 1;
      last_tx   <= tx_data;
    end
    if (rx_rd_en) rx_pops <= rx_pops + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lag, input int w_lag, input logic ovr_pulse,
                           output logic [1:0] resp, output logic push_seen);
    logic aw_done, w_done, aw_now, w_now;
    aw_done = 1'b0;
    w_done = 1'b0;
    push_seen = 1'b0;
    awaddr = addr;
    wdata = data;
    wstrb = strb;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (c == aw_lag && !aw_done) awvalid = 1'b1;
      if (c == w_lag && !w_done) wvalid = 1'b1;
      aw_now = awvalid && awready;
      w_now = wvalid && wready;
      if (ovr_pulse && (aw_done || aw_now) && (w_done || w_now)) rx_overrun = 1'b1;
      @(posedge clk); #1;
      rx_overrun = 1'b0;
      if (aw_now) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_now) begin w_done = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    check("write handshakes", {30'h0, aw_done, w_done}, 32'h3);
    for (int c = 0; c < 20 && !bvalid; c++) begin @(posedge clk); #1; end
    check("bvalid seen", bvalid, 1);
    resp = bresp;
    push_seen = tx_wr_en;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid dropped", bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_lag,
                          output logic [31:0] data, output logic [1:0] resp, output logic stable);
    logic got, ar_now;
    got = 1'b0;
    stable = 1'b1;
    araddr = addr;
    arvalid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      ar_now = arready;
      @(posedge clk); #1;
      if (ar_now) got = 1'b1;
    end
    arvalid = 1'b0;
    check("read handshake", got, 1);
    for (int c = 0; c < 20 && !rvalid; c++) begin @(posedge clk); #1; end
    check("rvalid seen", rvalid, 1);
    data = rdata;
    resp = rresp;
    for (int c = 0; c < rready_lag; c++) begin
      @(posedge clk); #1;
      if (!rvalid || rdata !== data || rresp !== resp) stable = 1'b0;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid dropped", rvalid, 0);
  endtask

  task automatic pulse_overrun();
    rx_overrun = 1'b1;
    @(posedge clk); #1;
    rx_overrun = 1'b0;
  endtask

  initial begin
    logic [31:0] data;
    logic [1:0]  resp;
    logic        stable, push;
    int          p0, q0;

    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    tx_full = 1'b0; rx_data = 8'h00; rx_empty = 1'b1; rx_overrun = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset handshake flags", {25'h0, awready, wready, arready, bvalid, rvalid, tx_wr_en, rx_rd_en}, 0);
    check("reset resps", {28'h0, bresp, rresp}, 0);
    check("reset rdata", rdata, 0);
    check("reset tx_data/ctrl", {21'h0, tx_data, ctrl}, 0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    check("readies after reset", {29'h0, awready, wready, arready}, 32'h7);

    axi_read(32'h08, 0, data, resp, stable);
    check("status after reset", data, 32'h2);
    check("status after reset resp", resp, 2'b00);
    axi_read(32'h0C, 0, data, resp, stable);
    check("ctrl after reset", data, 32'h0);
    check("ctrl after reset resp", resp, 2'b00);

    p0 = tx_pushes;
    axi_write(32'h00, 32'h41, 4'hF, 0, 3, 1'b0, resp, push);
    check("tx write resp", resp, 2'b00);
    check("tx push with bvalid", push, 1);
    check("tx push count", tx_pushes - p0, 1);
    check("tx pushed byte", last_tx, 8'h41);

    tx_full = 1'b1;
    p0 = tx_pushes;
    axi_write(32'h00, 32'h42, 4'hF, 0, 3, 1'b0, resp, push);
    check("tx full resp", resp, 2'b10);
    check("tx full no push", tx_pushes - p0, 0);
    tx_full = 1'b0;

    p0 = tx_pushes;
    axi_write(32'h00, 32'h43, 4'hE, 0, 0, 1'b0, resp, push);
    check("tx strb0 clear resp", resp, 2'b00);
    check("tx strb0 clear no push", tx_pushes - p0, 0);

    axi_write(32'h0C, 32'h5, 4'h1, 2, 0, 1'b0, resp, push);
    check("ctrl write W first resp", resp, 2'b00);
    check("ctrl output", ctrl, 3'b101);
    axi_write(32'h0C, 32'h7, 4'hE, 0, 0, 1'b0, resp, push);
    check("ctrl strb0 clear keeps", ctrl, 3'b101);
    axi_read(32'h0C, 0, data, resp, stable);
    check("ctrl readback", data, 32'h5);

    rx_data = 8'h5A;
    rx_empty = 1'b0;
    q0 = rx_pops;
    axi_read(32'h04, 4, data, resp, stable);
    check("rx read data", data, 32'h5A);
    check("rx read resp", resp, 2'b00);
    check("rx rvalid stable", stable, 1);
    check("rx single pop", rx_pops - q0, 1);
    rx_empty = 1'b1;
    q0 = rx_pops;
    axi_read(32'h04, 0, data, resp, stable);
    check("rx empty data", data, 32'h0);
    check("rx empty resp", resp, 2'b10);
    check("rx empty no pop", rx_pops - q0, 0);

    pulse_overrun();
    axi_read(32'h08, 0, data, resp, stable);
    check("overrun set", data, 32'h6);
    axi_write(32'h08, 32'h4, 4'hF, 0, 0, 1'b0, resp, push);
    check("status w1c resp", resp, 2'b00);
    axi_read(32'h08, 0, data, resp, stable);
    check("overrun cleared", data, 32'h2);
    axi_write(32'h08, 32'h4, 4'hF, 0, 0, 1'b1, resp, push);
    axi_read(32'h08, 0, data, resp, stable);
    check("overrun set wins over clear", data, 32'h6);

    axi_write(32'h10, 32'hDEAD_BEEF, 4'h3, 0, 0, 1'b0, resp, push);
`ifdef UART_REGS_SCRATCH_EN
    check("scratch write resp", resp, 2'b00);
    axi_read(32'h10, 0, data, resp, stable);
    check("scratch readback", data, 32'h0000_BEEF);
    check("scratch read resp", resp, 2'b00);
`else
    check("scratch absent write resp", resp, 2'b10);
    axi_read(32'h10, 0, data, resp, stable);
    check("scratch absent read data", data, 32'h0);
    check("scratch absent read resp", resp, 2'b10);
`endif
    axi_read(32'h18, 0, data, resp, stable);
    check("unmapped read data", data, 32'h0);
    check("unmapped read resp", resp, 2'b10);
    axi_write(32'h04, 32'h12, 4'hF, 0, 0, 1'b0, resp, push);
    check("rx_data write resp", resp, 2'b10);

    rx_data = 8'hC3;
    rx_empty = 1'b0;
    q0 = rx_pops;
    p0 = tx_pushes;
    awaddr = 32'h0C; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h04; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pending b/r before reset", {30'h0, bvalid, rvalid}, 32'h3);
    check("ctrl before reset", ctrl, 3'b011);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid reset flags", {28'h0, bvalid, rvalid, tx_wr_en, rx_rd_en}, 0);
    check("mid reset ctrl", ctrl, 3'b000);
    check("mid reset readies", {29'h0, awready, wready, arready}, 0);
    @(posedge clk); #1;
    check("mid reset pop count", rx_pops - q0, 1);
    check("mid reset push count", tx_pushes - p0, 0);
    rst_n = 1'b1;
    rx_empty = 1'b1;
    @(posedge clk); #1;
    axi_read(32'h0C, 0, data, resp, stable);
    check("ctrl after mid reset", data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
